// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the PC to a synchronous ROM and delivers
// (inst, inst_pc) pairs to decode over valid/ready, with a one-entry skid buffer.
module inst_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] rom_pc,
    input  logic [DATA_WIDTH-1:0] rom_inst,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic                  resp_vld;
    logic [DATA_WIDTH-1:0] resp_pc;
    logic                  skid_vld;
    logic [DATA_WIDTH-1:0] skid_inst;
    logic [DATA_WIDTH-1:0] skid_pc;
    logic                  stall;
    logic                  issue;

    assign rom_pc = fetch_pc;
    assign stall  = inst_valid && !inst_ready;
    // Never issue a read whose response could find both output and skid occupied.
    assign issue  = !skid_vld && !(resp_vld && stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            resp_vld   <= 1'b0;
            resp_pc    <= '0;
            skid_vld   <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (redirect) begin
            // The ROM read sampled at this edge belongs to the old path; squash it.
            fetch_pc   <= redirect_pc & ALIGN_MASK;
            resp_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            if (issue) begin
                resp_vld <= 1'b1;
                resp_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + PC_STEP;
            end else begin
                resp_vld <= 1'b0;
            end

            if (!stall) begin
                if (skid_vld) begin
                    inst_valid <= 1'b1;
                    inst       <= skid_inst;
                    inst_pc    <= skid_pc;
                    skid_vld   <= resp_vld;
                    if (resp_vld) begin
                        skid_inst <= rom_inst;
                        skid_pc   <= resp_pc;
                    end
                end else if (resp_vld) begin
                    inst_valid <= 1'b1;
                    inst       <= rom_inst;
                    inst_pc    <= resp_pc;
                end else begin
                    inst_valid <= 1'b0;
                end
            end else if (resp_vld) begin
                skid_vld  <= 1'b1;
                skid_inst <= rom_inst;
                skid_pc   <= resp_pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized stream checked
// against an expected-PC sequence and a ROM content table.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_pc;
    logic [31:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];
    logic [31:0] exp_pc;

    inst_fetch #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_pc     (rom_pc),
        .rom_inst   (rom_inst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the low 256 bytes are populated; everything else reads as zero.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a[31:8] == 24'h0) return mem[a[7:2]];
        return 32'h0;
    endfunction

    always @(posedge clk) rom_inst <= rom_word(rom_pc);

    task automatic test_reset;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h want 0/0/0", inst_valid, inst, inst_pc);
        end
        n_cmp++;
        if (rom_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rom_pc: got %h want 00000000", rom_pc);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0 || rom_pc !== 32'h4) begin
            n_err++;
            $display("FAIL reset_edge1: got valid=%b rom_pc=%h want 0/00000004", inst_valid, rom_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hE400FFFF) begin
            n_err++;
            $display("FAIL reset_edge2: got valid=%b pc=%h inst=%h want 1/00000000/e400ffff", inst_valid, inst_pc, inst);
        end
        exp_pc = 32'h4;
    endtask

    task automatic test_stream;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                n_err++;
                $display("FAIL stream: got valid=%b pc=%h inst=%h want 1/%h/%h", inst_valid, inst_pc, inst, exp_pc, rom_word(exp_pc));
            end
            exp_pc += 4;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] frozen;
        int got, run, max_run;
        frozen = '0;
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin
            n_err++;
            $display("FAIL bp_pre: got valid=%b pc=%h want 1/%h", inst_valid, inst_pc, exp_pc);
        end
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                n_err++;
                $display("FAIL bp_hold: got valid=%b pc=%h inst=%h want 1/%h/%h", inst_valid, inst_pc, inst, exp_pc, rom_word(exp_pc));
            end
            if (i == 0) begin
                frozen = rom_pc;
            end else begin
                n_cmp++;
                if (rom_pc !== frozen) begin
                    n_err++;
                    $display("FAIL bp_rom_pc_frozen: got %h want %h", rom_pc, frozen);
                end
            end
        end
        inst_ready = 1'b1;
        exp_pc += 4;
        got = 0;
        run = 0;
        max_run = 0;
        for (int i = 0; i < 10 && got < 4; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                n_cmp++;
                if (inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL bp_resume: got pc=%h inst=%h want %h/%h", inst_pc, inst, exp_pc, rom_word(exp_pc));
                end
                exp_pc += 4;
                got++;
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
            end
        end
        n_cmp++;
        if (got != 4 || max_run > 1) begin
            n_err++;
            $display("FAIL bp_throughput: got %0d pairs max_gap=%0d want 4 pairs max_gap<=1", got, max_run);
        end
    endtask

    task automatic test_jump;
        bit found;
        redirect    = 1'b1;
        redirect_pc = 32'h28;
        @(negedge clk);
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_pc == 32'h30) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL jump_reach_30: got no valid pc 00000030 want it within 8 cycles");
        end
        redirect    = 1'b1;
        redirect_pc = 32'h3C;
        @(negedge clk);
        redirect = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_bubble1: got valid=%b pc=%h want 0", inst_valid, inst_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL jump_bubble2: got valid=%b pc=%h want 0", inst_valid, inst_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h3C || inst !== mem[15]) begin
            n_err++;
            $display("FAIL jump_target: got valid=%b pc=%h inst=%h want 1/0000003c/%h", inst_valid, inst_pc, inst, mem[15]);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== mem[16]) begin
            n_err++;
            $display("FAIL jump_next: got valid=%b pc=%h inst=%h want 1/00000040/%h", inst_valid, inst_pc, inst, mem[16]);
        end
        exp_pc = 32'h44;
    endtask

    task automatic test_redirect_stall;
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h24;
        @(negedge clk);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstall_drop: got valid=%b pc=%h want 0", inst_valid, inst_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstall_bubble2: got valid=%b pc=%h want 0", inst_valid, inst_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h24 || inst !== mem[9]) begin
            n_err++;
            $display("FAIL rstall_target: got valid=%b pc=%h inst=%h want 1/00000024/%h", inst_valid, inst_pc, inst, mem[9]);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h28 || inst !== mem[10]) begin
            n_err++;
            $display("FAIL rstall_next: got valid=%b pc=%h inst=%h want 1/00000028/%h", inst_valid, inst_pc, inst, mem[10]);
        end
        exp_pc = 32'h2C;
    endtask

    task automatic test_wrap;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        inst_ready  = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_bubble: got valid=%b want 0", inst_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_top: got valid=%b pc=%h inst=%h want 1/fffffffc/00000000", inst_valid, inst_pc, inst);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hE400FFFF) begin
            n_err++;
            $display("FAIL wrap_zero: got valid=%b pc=%h inst=%h want 1/00000000/e400ffff", inst_valid, inst_pc, inst);
        end
        exp_pc = 32'h4;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || rom_pc !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b inst=%h pc=%h rom_pc=%h want all 0", inst_valid, inst, inst_pc, rom_pc);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_restart_edge1: got valid=%b want 0", inst_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hE400FFFF) begin
            n_err++;
            $display("FAIL async_restart: got valid=%b pc=%h inst=%h want 1/00000000/e400ffff", inst_valid, inst_pc, inst);
        end
        exp_pc = 32'h4;
    endtask

    task automatic test_random;
        int  bubbles, run;
        bit  prev_stall, redir;
        bubbles    = 0;
        run        = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bubbles > 0) begin
                n_cmp++;
                if (inst_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand_redirect_bubble: got valid=%b pc=%h want 0", inst_valid, inst_pc);
                end
                bubbles--;
            end else if (inst_valid) begin
                n_cmp++;
                if (inst_pc !== exp_pc || inst !== rom_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rand_pair: got pc=%h inst=%h want %h/%h", inst_pc, inst, exp_pc, rom_word(exp_pc));
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (inst_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_stall_hold: got valid=%b want 1", inst_valid);
                end
            end
            if (!inst_valid) begin
                run++;
                n_cmp++;
                if (run > 2) begin
                    n_err++;
                    $display("FAIL rand_gap: got %0d empty cycles want <=2", run);
                end
            end else begin
                run = 0;
            end
            redir      = ($urandom_range(0, 19) == 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect   = redir;
            if (redir) begin
                redirect_pc = 32'($urandom_range(0, 255));
                exp_pc      = redirect_pc & ~32'h3;
                bubbles     = 2;
                run         = 0;
            end else if (inst_valid && inst_ready) begin
                exp_pc += 4;
            end
            prev_stall = inst_valid && !inst_ready && !redir;
        end
        @(negedge clk);
        redirect   = 1'b0;
        inst_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hE400FFFF;
        mem[1] = 32'hE800FFFF;
        mem[5] = 32'h0;
        test_reset;
        test_stream;
        test_backpressure;
        test_jump;
        test_redirect_stall;
        test_wrap;
        test_async_reset;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
